rf_mp: RTL and testbench
========================

RF_MP -- requirements
Module: rf_mp

Interface
REQ-001 The block SHALL have a parameter XLEN, default 32, setting the data word width.
REQ-002 The block SHALL have a parameter NREG, default 32, setting the register count (power of 2, >=2); AW = log2(NREG).
REQ-003 The block SHALL have a parameter NRD, default 2, setting the read port count (1..4).
REQ-004 The block SHALL have a parameter NWR, default 2, setting the write port count (1..2).
REQ-005 The block SHALL have a parameter BYPASS, default 1; when 1, the write-to-read forwarding of REQ-014 is enabled.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port wr_en, input, NWR bits: per-port write enable.
REQ-009 The block SHALL have port wr_adr, input, NWR*AW bits: packed write addresses.
REQ-010 The block SHALL have port wr_dt, input, NWR*XLEN bits: packed write data.
REQ-011 The block SHALL have ports rd_adr (input, NRD*AW bits), rd_dt (output, NRD*XLEN bits) and rd_busy (output, NRD bits): packed read addresses, read data and per-port busy flags.
REQ-012 The block SHALL have ports sb_set (input, 1 bit), sb_adr (input, AW bits) and flush (input, 1 bit): scoreboard mark-pending, its address, and clear-all-pending.

Function
REQ-013 Register 0 SHALL read as zero on every port; writes to it and sb_set to it SHALL be ignored.
REQ-014 Reads SHALL be combinational; when BYPASS=1 and a same-cycle write (wr_en set) targets rd_adr (nonzero), rd_dt SHALL return that wr_dt; otherwise rd_dt SHALL return the stored value.
REQ-015 Writes SHALL commit on the rising clk edge; rd_dt with BYPASS=0 SHALL show new data from the cycle after the write.
REQ-016 When both write ports target the same nonzero address in one cycle, port NWR-1 SHALL win for storage and for bypass.
REQ-017 The scoreboard SHALL hold one busy bit per register; sb_set SHALL set busy[sb_adr] at the clk edge.
REQ-018 A committed write SHALL clear busy[wr_adr] at the clk edge.
REQ-019 When sb_set and a write hit the same address in one cycle, set SHALL win (busy ends at 1) and the data SHALL still be written.
REQ-020 flush SHALL clear all busy bits at the clk edge, overriding sb_set; register data SHALL be unaffected.
REQ-021 rd_busy[i] SHALL equal busy[rd_adr[i]], forced 0 when rd_adr[i]=0; when BYPASS=1, it SHALL also be 0 if a same-cycle write to that address clears it.
REQ-022 Reads SHALL never stall; the block SHALL NOT generate backpressure.

Reset
REQ-023 With rst=0 at a clk edge, all registers SHALL become 0 and all busy bits 0; writes, sb_set and flush in that cycle SHALL be ignored.
REQ-024 Reset asserted mid-sequence SHALL abandon pending scoreboard state with no residual effect after release.
REQ-025 Outputs SHALL reflect the cleared state (rd_dt=0, rd_busy=0) from the cycle after the reset edge.

Structure
REQ-026 A shared package SHALL define XLEN/NREG defaults, the AW derivation function, and the REG_ZERO constant.
REQ-027 The scoreboard SHALL be a separate sub-module rf_scoreboard (busy vector; set/clear/flush logic); the data array and bypass muxes SHALL reside in rf_mp.

Verification
REQ-028 Reset test: write x5=0xDEADBEEF, assert rst=0 for one edge, read x5 -> 0 and rd_busy=0.
REQ-029 Write-port conflict test: wr port0 x7=0x11111111 and port1 x7=0x22222222 in the same cycle -> x7=0x22222222 next cycle (and same cycle with BYPASS=1).
REQ-030 Bypass test: write x3=0x0000ABCD while rd_adr0=3 -> rd_dt0=0x0000ABCD in the same cycle with BYPASS=1, and the old value with BYPASS=0.
REQ-031 Register-zero test: write x0=0xFFFFFFFF plus sb_set x0 -> rd_dt=0 and rd_busy=0.
REQ-032 Scoreboard test: sb_set x9 -> rd_busy=1; write x9 -> rd_busy clears (same cycle if BYPASS=1); sb_set+write x9 together -> busy stays 1.
REQ-033 Flush test: sb_set x4, sb_set x12, then flush together with sb_set x20 -> all busy bits 0; data unchanged.

Source files
------------

// File: rtl/rf_mp_pkg.sv
// rf_mp_pkg: shared defaults, address-width derivation and the hard-wired zero register index.
package rf_mp_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;
    // Address width for a register count; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rf_mp_if.sv
// rf_mp_if: register-file bus bundle.
// Ports: wr_en/wr_adr/wr_dt (packed write ports), rd_adr/rd_dt/rd_busy (packed read ports),
//        sb_set/sb_adr (mark register pending), flush (clear all pending).
// master = requester side, slave = register file side.
interface rf_mp_if import rf_mp_pkg::*; #(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = aw_of(NREG);
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_adr;
    logic [NWR*XLEN-1:0] wr_dt;
    logic [NRD*AW-1:0]   rd_adr;
    logic [NRD*XLEN-1:0] rd_dt;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set;
    logic [AW-1:0]       sb_adr;
    logic                flush;
    modport master (output wr_en, wr_adr, wr_dt, rd_adr, sb_set, sb_adr, flush, input rd_dt, rd_busy);
    modport slave  (input wr_en, wr_adr, wr_dt, rd_adr, sb_set, sb_adr, flush, output rd_dt, rd_busy);
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per register.
// Ports: clk, rst (sync, active-low), i_set/i_adr (mark pending), i_clr (per-register write-commit
//        clear vector), i_flush (clear all), o_busy (pending vector, bit 0 always 0).
module rf_scoreboard import rf_mp_pkg::*; #(
    parameter int NREG = NREG_DEF,
    parameter int AW   = aw_of(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_set,
    input  logic [AW-1:0]   i_adr,
    input  logic [NREG-1:0] i_clr,
    input  logic            i_flush,
    output logic [NREG-1:0] o_busy
);
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;

    always_comb begin
        w_set = '0;
        if (i_set && i_adr != AW'(REG_ZERO)) w_set[i_adr] = 1'b1;
    end

    // Set is applied after clear so a same-cycle set and write leave the bit pending.
    always_ff @(posedge clk) begin
        if (!rst) r_busy <= '0;
        else r_busy <= i_flush ? '0 : (r_busy & ~i_clr) | w_set;
    end

    assign o_busy = r_busy;
endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with optional write-to-read bypass and a pending-write scoreboard.
// Ports: clk, rst (sync, active-low), bus (rf_mp_if.slave: write ports, combinational read ports
//        with busy flags, scoreboard set/flush).
module rf_mp import rf_mp_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic    clk,
    input  logic    rst,
    rf_mp_if.slave  bus
);
    localparam int AW = aw_of(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NWR-1:0]  w_wen;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy;

    // Effective write enables: register 0 and the reset cycle never write.
    always_comb begin
        w_wen = '0;
        w_clr = '0;
        for (int p = 0; p < NWR; p++) begin
            w_wen[p] = rst && bus.wr_en[p] && bus.wr_adr[p*AW +: AW] != AW'(REG_ZERO);
            if (w_wen[p]) w_clr[bus.wr_adr[p*AW +: AW]] = 1'b1;
        end
    end

    // Later ports are assigned last, so the highest port wins on an address clash.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (w_wen[p]) r_regs[bus.wr_adr[p*AW +: AW]] <= bus.wr_dt[p*XLEN +: XLEN];
        end
    end

    rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .i_set   (bus.sb_set),
        .i_adr   (bus.sb_adr),
        .i_clr   (w_clr),
        .i_flush (bus.flush),
        .o_busy  (w_busy)
    );

    always_comb begin
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_d;
        logic            w_b;
        bus.rd_dt   = '0;
        bus.rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            w_a = bus.rd_adr[r*AW +: AW];
            w_d = r_regs[w_a];
            w_b = w_busy[w_a];
            // Forwarded write also clears the busy flag unless a same-cycle set re-marks it.
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (w_wen[p] && bus.wr_adr[p*AW +: AW] == w_a) begin
                        w_d = bus.wr_dt[p*XLEN +: XLEN];
                        w_b = w_b && bus.sb_set && bus.sb_adr == w_a;
                    end
                end
            end
            if (w_a == AW'(REG_ZERO)) begin
                w_d = '0;
                w_b = 1'b0;
            end
            bus.rd_dt[r*XLEN +: XLEN] = w_d;
            bus.rd_busy[r]            = w_b;
        end
    end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed checks of rf_mp with bypass enabled (u1) and disabled (u0) driven in lockstep.
module tb_rf_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wr_en;
    logic [9:0]  wr_adr;
    logic [63:0] wr_dt;
    logic [9:0]  rd_adr;
    logic        sb_set;
    logic [4:0]  sb_adr;
    logic        flush;
    int          n_chk = 0;
    int          n_err = 0;

    rf_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) b1 ();
    rf_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) b0 ();

    assign b1.wr_en = wr_en;   assign b0.wr_en = wr_en;
    assign b1.wr_adr = wr_adr; assign b0.wr_adr = wr_adr;
    assign b1.wr_dt = wr_dt;   assign b0.wr_dt = wr_dt;
    assign b1.rd_adr = rd_adr; assign b0.rd_adr = rd_adr;
    assign b1.sb_set = sb_set; assign b0.sb_set = sb_set;
    assign b1.sb_adr = sb_adr; assign b0.sb_adr = sb_adr;
    assign b1.flush = flush;   assign b0.flush = flush;

    rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_adr = '0; wr_dt = '0; sb_set = 1'b0; sb_adr = '0; flush = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_adr[p*5 +: 5] = a;
        wr_dt[p*32 +: 32] = d;
    endtask

    task automatic rda(input logic [4:0] a0, input logic [4:0] a1);
        rd_adr = {a1, a0};
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_dt(input string tag, input int r, input logic [31:0] e1, input logic [31:0] e0);
        chk({tag, "/byp1"}, b1.rd_dt[r*32 +: 32], e1);
        chk({tag, "/byp0"}, b0.rd_dt[r*32 +: 32], e0);
    endtask

    task automatic chk_bz(input string tag, input int r, input logic e1, input logic e0);
        chk({tag, "/byp1"}, 32'(b1.rd_busy[r]), 32'(e1));
        chk({tag, "/byp0"}, 32'(b0.rd_busy[r]), 32'(e0));
    endtask

    initial begin
        idle();
        rd_adr = '0;
        tick();
        tick();
        rst = 1'b1;
        rda(5'd5, 5'd6);
        chk_dt("reset_dt", 0, 32'h0, 32'h0);
        chk_bz("reset_busy", 1, 1'b0, 1'b0);

        // Write x5 and mark x6 pending, then reset while also driving ignored traffic.
        wr(0, 5'd5, 32'hDEADBEEF);
        sb_set = 1'b1; sb_adr = 5'd6;
        tick();
        idle();
        rda(5'd5, 5'd6);
        chk_dt("x5_written", 0, 32'hDEADBEEF, 32'hDEADBEEF);
        chk_bz("x6_pending", 1, 1'b1, 1'b1);
        rst = 1'b0;
        wr(1, 5'd5, 32'h00001234);
        sb_set = 1'b1; sb_adr = 5'd7;
        tick();
        rst = 1'b1;
        idle();
        rda(5'd5, 5'd6);
        chk_dt("x5_after_rst", 0, 32'h0, 32'h0);
        chk_bz("x5_busy_after_rst", 0, 1'b0, 1'b0);
        chk_bz("x6_busy_after_rst", 1, 1'b0, 1'b0);
        rda(5'd5, 5'd7);
        chk_bz("x7_set_in_rst", 1, 1'b0, 1'b0);

        // Both write ports hit x7: port 1 wins.
        wr(0, 5'd7, 32'h11111111);
        wr(1, 5'd7, 32'h22222222);
        rda(5'd7, 5'd7);
        chk_dt("conflict_same", 0, 32'h22222222, 32'h0);
        tick();
        idle();
        rda(5'd7, 5'd7);
        chk_dt("conflict_next", 1, 32'h22222222, 32'h22222222);

        // Bypass of x3.
        wr(0, 5'd3, 32'h0000ABCD);
        rda(5'd3, 5'd7);
        chk_dt("bypass_same", 0, 32'h0000ABCD, 32'h0);
        tick();
        idle();
        rda(5'd3, 5'd7);
        chk_dt("bypass_next", 0, 32'h0000ABCD, 32'h0000ABCD);

        // Register zero ignores writes and set.
        wr(0, 5'd0, 32'hFFFFFFFF);
        sb_set = 1'b1; sb_adr = 5'd0;
        rda(5'd0, 5'd0);
        chk_dt("x0_same", 0, 32'h0, 32'h0);
        chk_bz("x0_busy_same", 0, 1'b0, 1'b0);
        tick();
        idle();
        rda(5'd0, 5'd0);
        chk_dt("x0_next", 1, 32'h0, 32'h0);
        chk_bz("x0_busy_next", 1, 1'b0, 1'b0);

        // Scoreboard on x9.
        sb_set = 1'b1; sb_adr = 5'd9;
        tick();
        idle();
        rda(5'd9, 5'd3);
        chk_bz("x9_set", 0, 1'b1, 1'b1);
        chk_bz("x3_not_set", 1, 1'b0, 1'b0);
        wr(1, 5'd9, 32'h00000055);
        rda(5'd9, 5'd3);
        chk_bz("x9_clr_same", 0, 1'b0, 1'b1);
        tick();
        idle();
        rda(5'd9, 5'd3);
        chk_bz("x9_clr_next", 0, 1'b0, 1'b0);
        chk_dt("x9_data", 0, 32'h00000055, 32'h00000055);
        wr(0, 5'd9, 32'h00000066);
        sb_set = 1'b1; sb_adr = 5'd9;
        tick();
        idle();
        rda(5'd9, 5'd3);
        chk_bz("x9_set_wins", 0, 1'b1, 1'b1);
        chk_dt("x9_data_set_wr", 0, 32'h00000066, 32'h00000066);

        // Flush overrides a same-cycle set.
        sb_set = 1'b1; sb_adr = 5'd4;
        tick();
        sb_adr = 5'd12;
        tick();
        idle();
        rda(5'd4, 5'd12);
        chk_bz("x4_set", 0, 1'b1, 1'b1);
        chk_bz("x12_set", 1, 1'b1, 1'b1);
        flush = 1'b1;
        sb_set = 1'b1; sb_adr = 5'd20;
        tick();
        idle();
        rda(5'd4, 5'd12);
        chk_bz("x4_flushed", 0, 1'b0, 1'b0);
        chk_bz("x12_flushed", 1, 1'b0, 1'b0);
        rda(5'd20, 5'd9);
        chk_bz("x20_flush_wins", 0, 1'b0, 1'b0);
        chk_bz("x9_flushed", 1, 1'b0, 1'b0);
        chk_dt("x9_kept", 1, 32'h00000066, 32'h00000066);
        rda(5'd3, 5'd7);
        chk_dt("x3_kept", 0, 32'h0000ABCD, 32'h0000ABCD);
        chk_dt("x7_kept", 1, 32'h22222222, 32'h22222222);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
